// File: rtl/tge_pkg.sv
// Shared types and constants for the 10GbE read-side depacketizer.
package tge_pkg;

  localparam int TGE_WORD_W = 64;
  localparam int TGE_PORT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } depktState_e;

endpackage

// File: rtl/depkt_event_counter.sv
// Wrapping event counter: counts one per enabled cycle, synchronous active-low reset.
module depkt_event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tge_read_depacketizer.sv
// Pairs 64-bit receive words of port-matched frames into 128-bit output words.
// Define DEPKT_LEN_CHECK_EN to also flag frames whose length differs from pkt_len.
module tge_read_depacketizer
  import tge_pkg::*;
#(
  parameter int DOUT_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TGE_WORD_W-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_eof,
  input  logic                  rx_bad_frame,
  input  logic [TGE_PORT_W-1:0] rx_source_port,
  input  logic [31:0]           config_rx_port,
  input  logic [31:0]           pkt_len,
  output logic                  rx_ack,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  depktState_e           state_q;
  logic [15:0]           wordCnt_q;
  logic                  pair_q;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic                  doutValid_q;
  logic                  doutLast_q;

  logic        portMatch;
  logic        frameEnd;
  logic        recvEnd;
  logic        dropEnd;
  logic        frameErr;
  logic [15:0] wordCntSat;
  logic        unusedBits;

  assign rx_ack     = rx_valid;
  assign portMatch  = (rx_source_port == config_rx_port[TGE_PORT_W-1:0]);
  assign frameEnd   = rx_valid & rx_eof;
  assign wordCntSat = (wordCnt_q == 16'hFFFF) ? wordCnt_q : wordCnt_q + 16'd1;

  assign recvEnd = frameEnd & (((state_q == IDLE) & portMatch) | (state_q == RECV));
  assign dropEnd = frameEnd & (((state_q == IDLE) & ~portMatch) | (state_q == DROP));

`ifdef DEPKT_LEN_CHECK_EN
  logic [31:0] pktLen_q;
  logic [31:0] lenRef;

  // The frame length includes the eof word itself; in IDLE pkt_len is read live.
  assign lenRef     = (state_q == IDLE) ? pkt_len : pktLen_q;
  assign frameErr   = rx_bad_frame | ({16'd0, wordCntSat} != lenRef);
  assign unusedBits = ^config_rx_port[31:16];

  always_ff @(posedge clk) begin
    if (!rst) begin
      pktLen_q <= '0;
    end else if (rx_valid && state_q == IDLE) begin
      pktLen_q <= pkt_len;
    end
  end
`else
  assign frameErr   = rx_bad_frame;
  assign unusedBits = ^{config_rx_port[31:16], pkt_len, wordCntSat};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      pair_q      <= 1'b0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      doutLast_q  <= 1'b0;
    end else begin
      doutValid_q <= 1'b0;
      doutLast_q  <= 1'b0;
      if (rx_valid) begin
        unique case (state_q)
          IDLE: begin
            if (portMatch) begin
              dout_q[DOUT_WIDTH-1 -: TGE_WORD_W] <= rx_data;
              state_q   <= RECV;
              pair_q    <= 1'b1;
              wordCnt_q <= 16'd1;
            end else begin
              state_q   <= DROP;
              pair_q    <= 1'b0;
              wordCnt_q <= 16'd1;
            end
            // Single-word frame: decide and finish in the same cycle.
            if (rx_eof) begin
              state_q   <= IDLE;
              pair_q    <= 1'b0;
              wordCnt_q <= '0;
              if (portMatch) begin
                dout_q[TGE_WORD_W-1:0] <= '0;
                doutValid_q            <= 1'b1;
                doutLast_q             <= 1'b1;
              end
            end
          end
          RECV: begin
            wordCnt_q <= wordCntSat;
            if (pair_q) begin
              dout_q[TGE_WORD_W-1:0] <= rx_data;
              doutValid_q            <= 1'b1;
              doutLast_q             <= rx_eof;
              pair_q                 <= 1'b0;
            end else begin
              dout_q[DOUT_WIDTH-1 -: TGE_WORD_W] <= rx_data;
              pair_q                             <= 1'b1;
              if (rx_eof) begin
                dout_q[TGE_WORD_W-1:0] <= '0;
                doutValid_q            <= 1'b1;
                doutLast_q             <= 1'b1;
              end
            end
            if (rx_eof) begin
              state_q   <= IDLE;
              pair_q    <= 1'b0;
              wordCnt_q <= '0;
            end
          end
          DROP: begin
            wordCnt_q <= wordCntSat;
            if (rx_eof) begin
              state_q   <= IDLE;
              wordCnt_q <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign dout_last  = doutLast_q;

  depkt_event_counter #(.WIDTH(CNT_WIDTH)) uPktCnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (recvEnd & ~frameErr),
    .count_o (pkt_cnt)
  );

  depkt_event_counter #(.WIDTH(CNT_WIDTH)) uDropCnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (dropEnd),
    .count_o (drop_cnt)
  );

  depkt_event_counter #(.WIDTH(CNT_WIDTH)) uErrCnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (recvEnd & frameErr),
    .count_o (err_cnt)
  );

endmodule

// File: tb/tb_tge_read_depacketizer.sv
// Randomized bench for tge_read_depacketizer with a frame-level reference model.
// Honours DEPKT_LEN_CHECK_EN the same way the design does.
module tb_tge_read_depacketizer;

  logic         clk;
  logic         rst;
  logic [63:0]  rx_data;
  logic         rx_valid;
  logic         rx_eof;
  logic         rx_bad_frame;
  logic [15:0]  rx_source_port;
  logic [31:0]  config_rx_port;
  logic [31:0]  pkt_len;
  logic         rx_ack;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_last;
  logic [31:0]  pkt_cnt;
  logic [31:0]  drop_cnt;
  logic [31:0]  err_cnt;

  typedef struct {
    logic [127:0] data;
    bit           last;
    int           edgeNum;
  } expWord_t;

  expWord_t    expQ[$];
  logic [63:0] frameWords[16];
  int          testCount = 0;
  int          failCount = 0;
  int          edgeCount = 0;
  int          expPkt = 0;
  int          expDrop = 0;
  int          expErr = 0;

  tge_read_depacketizer dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_eof         (rx_eof),
    .rx_bad_frame   (rx_bad_frame),
    .rx_source_port (rx_source_port),
    .config_rx_port (config_rx_port),
    .pkt_len        (pkt_len),
    .rx_ack         (rx_ack),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_last      (dout_last),
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Every output strobe must match the oldest outstanding model word, on the predicted edge.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        expWord_t e;
        e = expQ.pop_front();
        checkOutput("doutData", dout, e.data);
        checkOutput("doutLast", dout_last, e.last);
        checkOutput("doutLatency", edgeCount, e.edgeNum);
      end
    end else if (dout_last === 1'b1) begin
      checkOutput("lastWithoutValid", 1, 0);
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one valid word; on return the word was taken at edge edgeCount.
  task automatic applyStimulus(input logic [63:0] d, input bit eof, input bit bad);
    rx_data      = d;
    rx_valid     = 1'b1;
    rx_eof       = eof;
    rx_bad_frame = bad;
    @(posedge clk);
    #1;
    rx_valid     = 1'b0;
    rx_eof       = 1'($urandom_range(1, 0));
    rx_bad_frame = 1'($urandom_range(1, 0));
    rx_data      = {$urandom, $urandom};
  endtask

  task automatic pushExp(input logic [127:0] d, input bit last);
    expWord_t e;
    e.data    = d;
    e.last    = last;
    e.edgeNum = edgeCount;
    expQ.push_back(e);
  endtask

  // Sends the first sendCount words of an n-word frame from frameWords and updates the model.
  task automatic runFrame(input int n, input int sendCount, input logic [15:0] port,
                          input bit bad, input int maxGap);
    bit matched;
    bit lenBad;
    matched = (port == config_rx_port[15:0]);
    lenBad  = 1'b0;
`ifdef DEPKT_LEN_CHECK_EN
    lenBad  = (n != int'(pkt_len));
`endif
    rx_source_port = port;
    for (int i = 0; i < sendCount; i++) begin
      if (i > 0 && maxGap > 0) idleCycles($urandom_range(maxGap, 0));
      applyStimulus(frameWords[i], i == n - 1, (i == n - 1) && bad);
      if (matched) begin
        if (i % 2 == 1) pushExp({frameWords[i-1], frameWords[i]}, i == n - 1);
        else if (i == n - 1) pushExp({frameWords[i], 64'h0}, 1'b1);
      end
    end
    if (sendCount == n) begin
      if (!matched) expDrop++;
      else if (bad || lenBad) expErr++;
      else expPkt++;
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".pkt"}, pkt_cnt, expPkt);
    checkOutput({tag, ".drop"}, drop_cnt, expDrop);
    checkOutput({tag, ".err"}, err_cnt, expErr);
  endtask

  task automatic randomWords(input int n);
    for (int i = 0; i < n; i++) frameWords[i] = {$urandom, $urandom};
  endtask

  initial begin
    rst            = 1'b0;
    rx_data        = '0;
    rx_valid       = 1'b0;
    rx_eof         = 1'b0;
    rx_bad_frame   = 1'b0;
    rx_source_port = 16'h1234;
    config_rx_port = 32'hABCD_1234;
    pkt_len        = 32'd4;
    idleCycles(3);
    checkOutput("resetDout", dout, 0);
    checkOutput("resetValid", dout_valid, 0);
    checkOutput("resetLast", dout_last, 0);
    checkOutput("resetAck", rx_ack, 0);
    checkCounters("reset");
    rst = 1'b1;
    idleCycles(2);

    // Matched 4-word frame
    randomWords(4);
    runFrame(4, 4, 16'h1234, 1'b0, 0);
    idleCycles(2);
    checkCounters("fourWord");

    // Port mismatch, 6 words
    randomWords(6);
    runFrame(6, 6, 16'h9999, 1'b0, 2);
    idleCycles(2);
    checkCounters("dropFrame");

    // Odd-length frame pads the final low half with zero
    randomWords(3);
    runFrame(3, 3, 16'h1234, 1'b0, 0);
    idleCycles(2);
    checkCounters("threeWord");

    // Bad frame still emits its data
    randomWords(2);
    runFrame(2, 2, 16'h1234, 1'b1, 0);
    idleCycles(2);
    checkCounters("badFrame");

    // Single-word frame
    randomWords(1);
    runFrame(1, 1, 16'h1234, 1'b0, 0);
    idleCycles(2);
    checkCounters("oneWord");

`ifdef DEPKT_LEN_CHECK_EN
    pkt_len = 32'd4;
    randomWords(2);
    runFrame(2, 2, 16'h1234, 1'b0, 0);
    randomWords(4);
    runFrame(4, 4, 16'h1234, 1'b0, 1);
    idleCycles(2);
    checkCounters("lenCheck");
`endif

    // Reset after word 2 of a 4-word frame; the tail becomes a new frame
    pkt_len = 32'd2;
    randomWords(4);
    runFrame(4, 2, 16'h1234, 1'b0, 0);
    rst = 1'b0;
    idleCycles(1);
    checkOutput("midResetDout", dout, 0);
    checkOutput("midResetValid", dout_valid, 0);
    expPkt  = 0;
    expDrop = 0;
    expErr  = 0;
    checkCounters("midReset");
    rst = 1'b1;
    frameWords[0] = frameWords[2];
    frameWords[1] = frameWords[3];
    runFrame(2, 2, 16'h1234, 1'b0, 0);
    pkt_len = 32'd3;
    randomWords(3);
    runFrame(3, 3, 16'h1234, 1'b0, 1);
    idleCycles(2);
    checkCounters("afterReset");

    // Randomized frames with gaps, port changes and bad flags
    for (int f = 0; f < 40; f++) begin
      int n;
      logic [15:0] port;
      n = $urandom_range(8, 1);
      config_rx_port = $urandom;
      pkt_len = ($urandom_range(1, 0) == 1) ? 32'(n) : 32'($urandom_range(8, 1));
      port = ($urandom_range(9, 0) < 7) ? config_rx_port[15:0] : 16'($urandom);
      randomWords(n);
      runFrame(n, n, port, $urandom_range(4, 0) == 0, 3);
      idleCycles($urandom_range(2, 0));
      rx_valid = 1'b1;
      #1;
      checkOutput("ackFollowsValid", rx_ack, 1);
      rx_valid = 1'b0;
      #1;
      checkOutput("ackDropsWithValid", rx_ack, 0);
      checkCounters("random");
    end

    idleCycles(3);
    checkOutput("pendingOutputs", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/tge_read_depacketizer.md
TGE_READ_DEPACKETIZER -- requirements
Module: tge_read_depacketizer

Interface
REQ-001 Parameter DOUT_WIDTH, default 128, output word width; fixed at 2x the 64-bit receive word.
REQ-002 Parameter CNT_WIDTH, default 32, width of the status counters.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 rx_data  in  64  10GbE receive word.
REQ-006 rx_valid  in  1  rx_data valid.
REQ-007 rx_eof  in  1  last word of frame; qualified by rx_valid.
REQ-008 rx_bad_frame  in  1  frame corrupt; qualified by rx_valid & rx_eof.
REQ-009 rx_source_port  in  16  UDP source port; stable while rx_valid.
REQ-010 config_rx_port  in  32  accepted port; only bits [15:0] are used.
REQ-011 pkt_len  in  32  expected frame length in 64-bit words.
REQ-012 rx_ack  out  1  receive acknowledge to the 10GbE core.
REQ-013 dout  out  128  assembled word.
REQ-014 dout_valid  out  1  dout strobe.
REQ-015 dout_last  out  1  last dout word of the frame.
REQ-016 pkt_cnt, drop_cnt, err_cnt  out  CNT_WIDTH each  counters for accepted, port-dropped and errored frames.

Function
REQ-017 rx_ack SHALL equal rx_valid combinationally; the block never backpressures.
REQ-018 The FSM SHALL have states IDLE, RECV and DROP.
REQ-019 In IDLE, an rx_valid word SHALL go to RECV if rx_source_port equals config_rx_port[15:0], and to DROP otherwise.
REQ-020 RECV and DROP SHALL return to IDLE on rx_valid & rx_eof; a one-word frame SHALL return from the IDLE decision straight to IDLE.
REQ-021 In RECV, an even-indexed word (index 0, 2, ...) SHALL be latched into dout[127:64], and the following odd-indexed word SHALL fill dout[63:0].
REQ-022 dout_valid SHALL pulse one cycle after the odd-indexed word is accepted; latency is 1 cycle.
REQ-023 When eof falls on an even index, the block SHALL emit dout[63:0]=0 with dout_valid one cycle after eof.
REQ-024 dout_last SHALL assert only together with the dout_valid of the frame's final output word.
REQ-025 A DROP frame SHALL produce no dout_valid and SHALL increment drop_cnt at its eof.
REQ-026 rx_bad_frame at eof of a RECV frame SHALL increment err_cnt, and the frame SHALL NOT count in pkt_cnt; data already emitted is not retracted.
REQ-027 A good RECV frame SHALL increment pkt_cnt at eof.
REQ-028 The 16-bit in-frame word counter SHALL saturate at 0xFFFF.
REQ-029 All counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-030 rx_valid gaps of any length mid-frame SHALL NOT alter state or pairing.
REQ-031 Configuration inputs SHALL be sampled only in IDLE.

Reset
REQ-032 While rst=0, the FSM SHALL enter IDLE, the word counter and pair flag SHALL clear, and dout, dout_valid, dout_last and all counters SHALL be 0.
REQ-033 A reset mid-frame SHALL abandon the frame; the remaining words SHALL be treated as a new frame start.

Configuration
REQ-034 Macro DEPKT_LEN_CHECK_EN defined: a RECV frame whose word count at eof is not equal to pkt_len SHALL increment err_cnt instead of pkt_cnt; this is OR-ed with the rx_bad_frame condition, giving one increment per frame.
REQ-035 Macro undefined: pkt_len SHALL be ignored and no length comparison logic SHALL be synthesized.

Structure
REQ-036 Shared package tge_pkg SHALL hold the FSM state enum, the TGE_WORD_W=64 constant and the port-width constant.
REQ-037 One sub-module, depkt_event_counter (enable-driven, wrapping, sync active-low reset), SHALL be instantiated three times.

Verification
REQ-038 Port 0x1234 matches; 4-word frame with words A,B,C,D -> two dout {A,B},{C,D}, last on the second; pkt_cnt=1.
REQ-039 Source port 0x9999 with config 0x1234; 6-word frame -> no dout_valid; drop_cnt=1.
REQ-040 3-word frame X,Y,Z -> dout {X,Y} then {Z,0} with dout_last, one cycle after Z.
REQ-041 rx_bad_frame=1 at eof of a matched 2-word frame -> one dout, err_cnt=1, pkt_cnt=0.
REQ-042 With DEPKT_LEN_CHECK_EN and pkt_len=4, a 2-word frame -> err_cnt=1; a following 4-word frame -> pkt_cnt=1.
REQ-043 rst=0 after word 2 of a 4-word frame -> outputs zero; remaining words treated as a new frame; a following clean frame decodes correctly.
